store_merge_unit: RTL
=====================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory bus width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=double.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  store byte address.
REQ-009 SHALL have port req_data  input  DATA_WIDTH  store value, right-aligned.
REQ-010 SHALL have port mem_address  output  ADDR_WIDTH  lane-aligned address; low log2(DATA_WIDTH/8) bits zero.
REQ-011 SHALL have ports mem_read and mem_write  output  1 each  memory read and write strobes.
REQ-012 SHALL have port mem_writedata  output  DATA_WIDTH  merged write data.
REQ-013 SHALL have port mem_readdata  input  DATA_WIDTH  memory read data.
REQ-014 SHALL have port mem_waitrequest  input  1  memory stall; high extends the current access.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port misaligned  output  1  pulses with done when the request was rejected.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready high only in IDLE.
REQ-018 SHALL accept a request on a clock edge with req_valid and req_ready high, latching req_size, req_addr and req_data; req_valid is ignored outside IDLE.
REQ-019 SHALL flag as misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0; size 3 when DATA_WIDTH=32.
REQ-020 SHALL transition IDLE->RESP on misaligned accept, with no memory access.
REQ-021 SHALL transition IDLE->WR when the store size equals DATA_WIDTH, with no read.
REQ-022 SHALL transition IDLE->RD on all other accepts.
REQ-023 SHALL in RD hold mem_read=1, and on the first edge with mem_waitrequest=0 capture mem_readdata, then go to WR.
REQ-024 SHALL in WR hold mem_write=1 with mem_writedata stable, and on the first edge with mem_waitrequest=0 go to RESP.
REQ-025 SHALL in RESP assert done for exactly one cycle, then return to IDLE.
REQ-026 SHALL define byte lane k as bits [8k+7:8k] (little-endian), with offset = addr mod (DATA_WIDTH/8).
REQ-027 SHALL merge by placing size bytes of req_data into lanes offset upward, taking all other lanes from the captured read word.
REQ-028 SHALL never assert mem_read and mem_write in the same cycle.
REQ-029 SHALL hold mem_address, mem_read, mem_write and mem_writedata constant while mem_waitrequest is high.
REQ-030 SHALL, with zero wait states, give latency from the accept edge to done: partial store 3 cycles, full-width store 2 cycles, misaligned 1 cycle.

Reset
REQ-031 SHALL on an edge with reset=0 enter IDLE with req_ready=1 and mem_read, mem_write, done and misaligned at 0; mem_address and mem_writedata at 0.
REQ-032 SHALL on reset during RD or WR abandon the access, deassert the strobes at that edge, and not emit done.

Verification
REQ-033 SHALL verify: DATA_WIDTH=32, SB addr 0x103, data 0xAB, readdata 0x11223344 -> mem_address 0x100, mem_writedata 0xAB223344, done 3 cycles after accept.
REQ-034 SHALL verify: SH addr 0x202, data 0xBEEF, readdata 0x11223344, 2-cycle waitrequest in RD -> mem_writedata 0xBEEF3344, strobes stable throughout the stall.
REQ-035 SHALL verify: SW addr 0x40, data 0xDEADBEEF -> no mem_read, mem_write with 0xDEADBEEF, done 2 cycles after accept.
REQ-036 SHALL verify: SH addr 0x41 -> misaligned=1 and done=1 one cycle after accept, no strobes.
REQ-037 SHALL verify: DATA_WIDTH=64, SW addr 0x1004, data 0xCAFEF00D, readdata 0x0011223344556677 -> mem_address 0x1000, mem_writedata 0xCAFEF00D44556677.
REQ-038 SHALL verify: reset=0 asserted mid-WR with waitrequest high -> mem_write=0 at the next edge, no done, req_ready=1.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store merge unit: turns byte/half/word/double stores into lane-aligned bus
// writes, doing a read-modify-write when the store is narrower than the bus.
module store_merge_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_waitrequest,
  output logic                  done,
  output logic                  misaligned
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state, next_state;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  misaligned_q;
  logic                  accept;
  logic                  req_misaligned;
  logic                  req_full;
  logic [DATA_WIDTH-1:0] shifted_data;
  logic [DATA_WIDTH-1:0] merged_word;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign done      = (state == RESP);
  assign misaligned = (state == RESP) && misaligned_q;

  // A double store can never be legal on a 32-bit bus.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'd1:    req_misaligned = req_addr[0];
      2'd2:    req_misaligned = |req_addr[1:0];
      2'd3:    req_misaligned = (DATA_WIDTH == 32) || (|req_addr[2:0]);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_full = ((DATA_WIDTH == 32) && (req_size == 2'd2)) ||
                    ((DATA_WIDTH == 64) && (req_size == 2'd3));

  // Lanes covered by the store take shifted store data, the rest keep read data.
  always_comb begin
    shifted_data = data_q << {off_q, 3'b000};
    merged_word  = mem_readdata;
    for (int k = 0; k < NBYTES; k++) begin
      if ((k >= int'(off_q)) && (k < int'(off_q) + int'(32'd1 << size_q)))
        merged_word[8*k +: 8] = shifted_data[8*k +: 8];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_misaligned)  next_state = RESP;
          else if (req_full)   next_state = WR;
          else                 next_state = RD;
        end
      end
      RD:      if (!mem_waitrequest) next_state = WR;
      WR:      if (!mem_waitrequest) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Write data is loaded only at accept (full store) or at read completion,
  // so it stays frozen for the whole write phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      size_q        <= '0;
      off_q         <= '0;
      data_q        <= '0;
      misaligned_q  <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        size_q       <= req_size;
        off_q        <= req_addr[OFF_W-1:0];
        data_q       <= req_data;
        misaligned_q <= req_misaligned;
        mem_address  <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        if (req_full)
          mem_writedata <= req_data;
      end
      if ((state == RD) && !mem_waitrequest)
        mem_writedata <= merged_word;
    end
  end

endmodule
